// File: rtl/xc20xx_cfg_ctrl.sv
// rtl/xc20xx_cfg_ctrl.sv - serial configuration bitstream loader for XC20xx storage elements
//
// Purpose:
//   Consumes a qualified serial bitstream made of a preamble, a frame count,
//   sync bits, framed config words and postamble bits. It writes each valid
//   frame out as a parallel word with its frame index. The block raises DONE
//   and CFG_EN after a clean load, or a sticky ERR on any format violation.
//
// Ports:
//   K           clock, rising edge
//   RST_N       asynchronous active-low reset
//   DIN         serial bitstream bit
//   DIN_VLD     DIN qualifier; a bit is consumed only when high
//   FRAME_DATA  config word of the last completed frame (holds between writes)
//   FRAME_ADDR  index of the frame on FRAME_DATA (holds between writes)
//   FRAME_WE    one-cycle write strobe for FRAME_DATA/FRAME_ADDR
//   BUSY        high in every state except IDLE, DONE and ERROR
//   DONE        configuration completed successfully
//   CFG_EN      storage-element enable, follows DONE
//   ERR         sticky bitstream format error

module xc20xx_cfg_ctrl #(
  parameter int FRAME_BITS = 9,
  parameter int ADDR_BITS  = 16
) (
  input  logic                  K,
  input  logic                  RST_N,
  input  logic                  DIN,
  input  logic                  DIN_VLD,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [ADDR_BITS-1:0]  FRAME_ADDR,
  output logic                  FRAME_WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CFG_EN,
  output logic                  ERR
);

  // One shared bit counter serves LEN, SYNC, FRAME_DATA and POST.
  localparam int CNT_MAX = (ADDR_BITS > FRAME_BITS) ? ADDR_BITS : FRAME_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [7:0]       PREAMBLE  = 8'b1111_0010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_SYNC,
    S_FSTART,
    S_FDATA,
    S_FSTOP,
    S_POST,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            hist_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_BITS-1:0]  n_q;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [FRAME_BITS-1:0] shift_q;

  logic [7:0]            hist_next;
  logic [ADDR_BITS-1:0]  len_next;
  logic [FRAME_BITS-1:0] shift_next;
  logic                  last_frame;

  logic                  busy_d;
  logic                  done_d;
  logic                  err_d;
  logic                  we_d;

  assign hist_next  = {hist_q[6:0], DIN};
  assign len_next   = {n_q[ADDR_BITS-2:0], DIN};
  assign shift_next = {shift_q[FRAME_BITS-2:0], DIN};
  // N is never 0 past LEN, so N-1 cannot underflow here.
  assign last_frame = (idx_q == (n_q - ADDR_BITS'(1)));

  // State register
  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every transition needs a consumed bit
  always_comb begin
    state_d = state_q;
    if (DIN_VLD) begin
      case (state_q)
        S_IDLE: begin
          if (hist_next == PREAMBLE) state_d = S_LEN;
        end
        S_LEN: begin
          if (cnt_q == LEN_LAST) state_d = (len_next != '0) ? S_SYNC : S_ERROR;
        end
        S_SYNC: begin
          if (!DIN)                    state_d = S_ERROR;
          else if (cnt_q == SYNC_LAST) state_d = S_FSTART;
        end
        S_FSTART: begin
          state_d = DIN ? S_ERROR : S_FDATA;
        end
        S_FDATA: begin
          if (cnt_q == DATA_LAST) state_d = S_FSTOP;
        end
        S_FSTOP: begin
          if (!DIN)           state_d = S_ERROR;
          else if (last_frame) state_d = S_POST;
          else                 state_d = S_FSTART;
        end
        S_POST: begin
          if (!DIN)                    state_d = S_ERROR;
          else if (cnt_q == SYNC_LAST) state_d = S_DONE;
        end
        default: state_d = state_q;  // DONE and ERROR are terminal until reset
      endcase
    end
  end

  // Output decode from the next state; registered below so status lands
  // the cycle after the deciding bit.
  always_comb begin
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
    we_d   = DIN_VLD && (state_q == S_FSTOP) && DIN;
  end

  // Datapath and registered outputs
  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      hist_q     <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      FRAME_DATA <= '0;
      FRAME_ADDR <= '0;
      FRAME_WE   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CFG_EN     <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      BUSY     <= busy_d;
      DONE     <= done_d;
      CFG_EN   <= done_d;
      ERR      <= err_d;
      // The strobe is not gated by DIN_VLD in the following cycle.
      FRAME_WE <= we_d;
      if (we_d) begin
        FRAME_DATA <= shift_q;
        FRAME_ADDR <= idx_q;
      end
      if (DIN_VLD) begin
        if (state_q == S_IDLE)  hist_q  <= hist_next;
        if (state_q == S_LEN)   n_q     <= len_next;
        if (state_q == S_FDATA) shift_q <= shift_next;
        if (we_d)               idx_q   <= idx_q + ADDR_BITS'(1);
        // The counter restarts on every state change, so each phase counts from 0.
        if (state_d != state_q) begin
          cnt_q <= '0;
        end else if ((state_q == S_LEN) || (state_q == S_SYNC) ||
                     (state_q == S_FDATA) || (state_q == S_POST)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xc20xx_cfg_ctrl.sv
// tb/tb_xc20xx_cfg_ctrl.sv - self-checking bench for xc20xx_cfg_ctrl

module tb_xc20xx_cfg_ctrl;

  localparam int FB = 9;
  localparam int AB = 16;

  logic          K = 1'b0;
  logic          RST_N = 1'b0;
  logic          DIN = 1'b0;
  logic          DIN_VLD = 1'b0;
  logic [FB-1:0] FRAME_DATA;
  logic [AB-1:0] FRAME_ADDR;
  logic          FRAME_WE;
  logic          BUSY;
  logic          DONE;
  logic          CFG_EN;
  logic          ERR;

  always #5 K = ~K;

  xc20xx_cfg_ctrl #(.FRAME_BITS(FB), .ADDR_BITS(AB)) dut (
    .K          (K),
    .RST_N      (RST_N),
    .DIN        (DIN),
    .DIN_VLD    (DIN_VLD),
    .FRAME_DATA (FRAME_DATA),
    .FRAME_ADDR (FRAME_ADDR),
    .FRAME_WE   (FRAME_WE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .CFG_EN     (CFG_EN),
    .ERR        (ERR)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [AB-1:0] we_addr_q[$];
  logic [FB-1:0] we_data_q[$];

  // Collect every write strobe, sampled away from the rising edge.
  always @(negedge K) begin
    if (FRAME_WE) begin
      we_addr_q.push_back(FRAME_ADDR);
      we_data_q.push_back(FRAME_DATA);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    DIN_VLD = 1'b0;
    DIN     = 1'($urandom_range(0, 1));
    @(posedge K);
    #1;
  endtask

  // Drives one qualified bit; returns just after the edge that consumed it.
  task automatic send_bit(input logic b);
    DIN     = b;
    DIN_VLD = 1'b1;
    @(posedge K);
    #1;
    DIN_VLD = 1'b0;
    DIN     = 1'($urandom_range(0, 1));
  endtask

  task automatic send_stream(input logic [127:0] bits, input int nbits, input bit gaps);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (gaps) begin
        for (int g = 0; g < 8 && ($urandom_range(0, 1) == 1); g++) idle_cycle();
      end
      send_bit(bits[i]);
    end
  endtask

  task automatic do_reset(input string name);
    RST_N = 1'b0;
    #1;
    chk({name, "_reset"}, {2'b0, FRAME_WE, BUSY, DONE, CFG_EN, ERR, FRAME_ADDR, FRAME_DATA}, 32'h0);
    we_addr_q.delete();
    we_data_q.delete();
    @(posedge K);
    #1;
    RST_N = 1'b1;
  endtask

  typedef struct {
    string          name;
    logic [127:0]   bits;
    int             nbits;
    bit             gaps;
    int             n_we;
    logic [AB-1:0]  a0;
    logic [FB-1:0]  d0;
    logic [AB-1:0]  a1;
    logic [FB-1:0]  d1;
    logic           busy;
    logic           done;
    logic           cfg_en;
    logic           err;
  } vec_t;

  vec_t tbl[8];

  logic [53:0] good;
  logic [53:0] bad_pre;
  logic [42:0] len_zero;
  logic [103:0] stop_bad;
  logic [42:0] sync_bad;
  logic [42:0] post_bad;
  logic [78:0] done_ign;

  task automatic check_writes(input string name, input int n_we,
                              input logic [AB-1:0] a0, input logic [FB-1:0] d0,
                              input logic [AB-1:0] a1, input logic [FB-1:0] d1);
    chk({name, "_we_count"}, we_addr_q.size(), n_we);
    if (n_we >= 1) begin
      chk({name, "_addr0"}, (we_addr_q.size() > 0) ? 32'(we_addr_q[0]) : 32'hxxxx_xxxx, a0);
      chk({name, "_data0"}, (we_data_q.size() > 0) ? 32'(we_data_q[0]) : 32'hxxxx_xxxx, d0);
    end
    if (n_we >= 2) begin
      chk({name, "_addr1"}, (we_addr_q.size() > 1) ? 32'(we_addr_q[1]) : 32'hxxxx_xxxx, a1);
      chk({name, "_data1"}, (we_data_q.size() > 1) ? 32'(we_data_q[1]) : 32'hxxxx_xxxx, d1);
    end
  endtask

  initial begin
    good     = {8'hF2, 16'h0002, 4'hF, 1'b0, 9'h165, 1'b1, 1'b0, 9'h09A, 1'b1, 4'hF};
    bad_pre  = {8'hF6, good[45:0]};
    len_zero = {8'hF2, 16'h0000, 4'hF, 1'b0, 9'h165, 1'b1, 4'hF};
    stop_bad = {8'hF2, 16'h0002, 4'hF, 1'b0, 9'h165, 1'b1, 1'b0, 9'h09A, 1'b0, good};
    sync_bad = {8'hF2, 16'h0002, 4'b1101, 1'b0, 9'h165, 1'b1, 4'hF};
    post_bad = {8'hF2, 16'h0001, 4'hF, 1'b0, 9'h165, 1'b1, 4'b1011};
    done_ign = {good, 1'b0, 8'hF2, 16'h0001};

    //        name          bits             n    gap we a0     d0      a1     d1      bsy  dn   cfg  err
    tbl[0] = '{"good",      128'(good),      54,  0,  2, 16'd0, 9'h165, 16'd1, 9'h09A, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{"good_gaps", 128'(good),      54,  1,  2, 16'd0, 9'h165, 16'd1, 9'h09A, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{"len_zero",  128'(len_zero),  43,  0,  0, 16'd0, 9'h000, 16'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{"stop_bad",  128'(stop_bad),  104, 0,  1, 16'd0, 9'h165, 16'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{"bad_pre",   128'(bad_pre),   54,  0,  0, 16'd0, 9'h000, 16'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{"sync_bad",  128'(sync_bad),  43,  0,  0, 16'd0, 9'h000, 16'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{"post_bad",  128'(post_bad),  43,  1,  1, 16'd0, 9'h165, 16'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{"done_ign",  128'(done_ign),  79,  0,  2, 16'd0, 9'h165, 16'd1, 9'h09A, 1'b0, 1'b1, 1'b1, 1'b0};

    @(posedge K);
    #1;

    foreach (tbl[v]) begin
      do_reset(tbl[v].name);
      send_stream(tbl[v].bits, tbl[v].nbits, tbl[v].gaps);
      for (int i = 0; i < 3; i++) idle_cycle();
      @(negedge K);
      check_writes(tbl[v].name, tbl[v].n_we, tbl[v].a0, tbl[v].d0, tbl[v].a1, tbl[v].d1);
      chk({tbl[v].name, "_busy"},   BUSY,   tbl[v].busy);
      chk({tbl[v].name, "_done"},   DONE,   tbl[v].done);
      chk({tbl[v].name, "_cfg_en"}, CFG_EN, tbl[v].cfg_en);
      chk({tbl[v].name, "_err"},    ERR,    tbl[v].err);
      @(posedge K);
      #1;
    end

    // Zero frame count: ERR lands exactly one cycle after the 16th length bit.
    do_reset("nzero_t");
    send_stream(128'h0F2, 8, 0);
    send_stream(128'h0, 15, 0);
    @(negedge K);
    chk("nzero_t_busy_before", BUSY, 1'b1);
    chk("nzero_t_err_before", ERR, 1'b0);
    @(posedge K);
    #1;
    send_bit(1'b0);
    @(negedge K);
    chk("nzero_t_err_after", ERR, 1'b1);
    chk("nzero_t_busy_after", BUSY, 1'b0);
    chk("nzero_t_done_after", DONE, 1'b0);
    @(posedge K);
    #1;

    // Write strobe timing with DIN_VLD low after the stop bit, then hold and freeze.
    do_reset("we_t");
    send_stream({8'hF2, 16'h0001, 4'hF, 1'b0, 9'h165, 1'b1}, 39, 0);
    @(negedge K);
    chk("we_t_we_high", FRAME_WE, 1'b1);
    chk("we_t_addr", FRAME_ADDR, 16'd0);
    chk("we_t_data", FRAME_DATA, 9'h165);
    @(posedge K);
    #1;
    for (int i = 0; i < 5; i++) idle_cycle();
    @(negedge K);
    chk("we_t_we_low", FRAME_WE, 1'b0);
    chk("we_t_data_hold", FRAME_DATA, 9'h165);
    chk("we_t_busy_frozen", BUSY, 1'b1);
    @(posedge K);
    #1;
    send_stream(128'h7, 3, 1);
    @(negedge K);
    chk("we_t_done_early", DONE, 1'b0);
    @(posedge K);
    #1;
    send_bit(1'b1);
    @(negedge K);
    chk("we_t_done", DONE, 1'b1);
    chk("we_t_cfg_en", CFG_EN, 1'b1);
    @(posedge K);
    #1;

    // Reset in the middle of frame 0 data, then a full resend.
    do_reset("rst_mid");
    send_stream({8'hF2, 16'h0002, 4'hF, 1'b0, 4'b1011}, 33, 0);
    @(negedge K);
    chk("rst_mid_busy_before", BUSY, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_mid_outputs", {2'b0, FRAME_WE, BUSY, DONE, CFG_EN, ERR, FRAME_ADDR, FRAME_DATA}, 32'h0);
    @(posedge K);
    #1;
    @(posedge K);
    #1;
    chk("rst_mid_no_we", we_addr_q.size(), 0);
    RST_N = 1'b1;
    send_stream(128'(good), 54, 0);
    for (int i = 0; i < 3; i++) idle_cycle();
    @(negedge K);
    check_writes("rst_mid", 2, 16'd0, 9'h165, 16'd1, 9'h09A);
    chk("rst_mid_done", DONE, 1'b1);
    chk("rst_mid_cfg_en", CFG_EN, 1'b1);
    chk("rst_mid_err", ERR, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/xc20xx_cfg_ctrl.md
XC20XX_CFG_CTRL -- requirements
Module: xc20xx_cfg_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 9, meaning data bits per configuration frame (one storage-element config word).
REQ-002 SHALL have parameter ADDR_BITS, default 16, meaning width of the frame count and the frame address.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-004 K  input  1  clock, all state changes on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 DIN  input  1  serial bitstream bit.
REQ-007 DIN_VLD  input  1  DIN qualifier; a bit is consumed only on rising K with DIN_VLD=1.
REQ-008 FRAME_DATA  output  FRAME_BITS  parallel config word of the last completed frame.
REQ-009 FRAME_ADDR  output  ADDR_BITS  index of the frame on FRAME_DATA.
REQ-010 FRAME_WE  output  1  one-cycle write strobe for FRAME_DATA/FRAME_ADDR.
REQ-011 BUSY  output  1  high in every state except IDLE, DONE, ERROR.
REQ-012 DONE  output  1  configuration completed successfully.
REQ-013 CFG_EN  output  1  storage-element enable; low until DONE.
REQ-014 ERR  output  1  sticky bitstream format error.

Function
REQ-015 SHALL implement states IDLE, LEN, SYNC, FRAME_START, FRAME_DATA, FRAME_STOP, POST, DONE, ERROR; every transition occurs only on a consumed bit.
REQ-016 IDLE: keep 8-bit history of consumed bits; go to LEN when history (oldest first) equals 1111_0010.
REQ-017 LEN: shift ADDR_BITS bits MSB-first into frame count N; after the last bit go to SYNC if N!=0, else ERROR.
REQ-018 SYNC: expect 4 consecutive 1 bits; any 0 -> ERROR; after fourth 1 -> FRAME_START.
REQ-019 FRAME_START: bit 0 -> FRAME_DATA; bit 1 -> ERROR.
REQ-020 FRAME_DATA: shift FRAME_BITS bits MSB-first; after the last -> FRAME_STOP.
REQ-021 FRAME_STOP: bit 1 -> frame valid; bit 0 -> ERROR, no write for that frame.
REQ-022 On a valid stop bit, in the next cycle FRAME_WE=1 for exactly one cycle with FRAME_DATA = shifted word and FRAME_ADDR = frame index; FRAME_DATA/FRAME_ADDR hold until the next write.
REQ-023 Frame index starts at 0, increments by 1 per valid frame; after frame N-1 go to POST, else FRAME_START.
REQ-024 No wrap-around: N <= 2^ADDR_BITS-1, so the index never exceeds 2^ADDR_BITS-2.
REQ-025 POST: expect 4 consecutive 1 bits; any 0 -> ERROR; after fourth 1 -> DONE.
REQ-026 DONE: DONE=1, CFG_EN=1; all further DIN ignored until reset.
REQ-027 ERROR: ERR=1, CFG_EN=0, no further FRAME_WE; all further DIN ignored until reset.
REQ-028 Cycles with DIN_VLD=0 SHALL freeze all state and counters; FRAME_WE timing is unaffected (still the cycle after the stop bit).
REQ-029 DONE, ERR, CFG_EN and BUSY SHALL be registered outputs, updating the cycle after the deciding bit.

Reset
REQ-030 RST_N=0 SHALL immediately force state IDLE, history to 0, counters to 0, FRAME_DATA=0, FRAME_ADDR=0, FRAME_WE=0, BUSY=0, DONE=0, CFG_EN=0, ERR=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no FRAME_WE; after release a complete new bitstream is required.

Verification
REQ-032 Good stream, FRAME_BITS=9: 11110010, N=0x0002, 1111, 0 1_0110_0101 1, 0 0_1001_1010 1, 1111 -> WE with ADDR 0 DATA 0x165, WE with ADDR 1 DATA 0x09A, then DONE=1, CFG_EN=1, ERR=0.
REQ-033 Same stream with DIN_VLD randomly low 50% of cycles -> identical writes and final outputs.
REQ-034 N=0x0000 -> ERR=1 the cycle after the 16th length bit, no WE, DONE=0.
REQ-035 Frame 1 stop bit = 0 -> exactly one WE (ADDR 0), then ERR=1; later bits ignored.
REQ-036 Preamble 11110110 then valid remainder -> stays IDLE, BUSY=0, no WE.
REQ-037 RST_N pulsed low during frame 0 data bits -> all outputs 0 immediately; full resend gives the REQ-032 result.
